// File: rtl/wvb_ovf_ctrl_multi_pkg.sv
// Shared constants for the multi-channel waveform buffer overflow controller.
// Holds the default geometry and the saturation value of the overflow event
// counter at its default width.
package wvb_ovf_ctrl_multi_pkg;

    // Default number of waveform buffer channels
    localparam int L_N_CHAN_DEF    = 8;

    // Default waveform buffer address width
    localparam int L_ADR_WIDTH_DEF = 12;

    // Default overflow event counter width
    localparam int L_CNT_WIDTH_DEF = 16;

    // Saturation value of the overflow event counter at the default width
    localparam logic [L_CNT_WIDTH_DEF-1:0] L_OVF_CNT_MAX = '1;

endpackage : wvb_ovf_ctrl_multi_pkg

// File: rtl/wvb_ovf_ctrl_chan.sv
// One channel of the waveform buffer overflow controller.
// Tracks the last read address of one buffer, derives the used word count and
// the overflow condition, and keeps the sticky flag, the saturating overflow
// event counter and the high-water mark. Every output is a register.
module wvb_ovf_ctrl_chan
    import wvb_ovf_ctrl_multi_pkg::*;
#(
    parameter int P_ADR_WIDTH = L_ADR_WIDTH_DEF,
    parameter int P_CNT_WIDTH = L_CNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [P_ADR_WIDTH-1:0] wr_addr,
    input  logic [P_ADR_WIDTH-1:0] stop_addr,
    input  logic                   rddone,
    input  logic                   hdr_full,
    input  logic [P_ADR_WIDTH-1:0] af_thresh,
    input  logic                   ovf_clr,
    input  logic                   hwm_clr,
    output logic                   overflow,
    output logic                   almost_full,
    output logic                   ovf_sticky,
    output logic [P_ADR_WIDTH-1:0] wused,
    output logic [P_ADR_WIDTH-1:0] wused_hwm,
    output logic [P_CNT_WIDTH-1:0] ovf_cnt
);

    // Counter ceiling and the all-ones address used as the reset read pointer
    localparam logic [P_CNT_WIDTH-1:0] L_CNT_MAX  = {P_CNT_WIDTH{1'b1}};
    localparam logic [P_ADR_WIDTH-1:0] L_ADR_ONES = {P_ADR_WIDTH{1'b1}};
    localparam logic [P_ADR_WIDTH-1:0] L_ADR_ONE  = {{(P_ADR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [P_CNT_WIDTH-1:0] L_CNT_ONE  = {{(P_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [P_ADR_WIDTH-1:0] last_rd_addr;
    logic [P_ADR_WIDTH-1:0] next_rd;
    logic [P_ADR_WIDTH-1:0] wused_diff;
    logic [P_ADR_WIDTH-1:0] wused_n;
    logic                   adr_match;
    logic                   ovf_n;
    logic                   rise;
    logic                   af_n;
    logic                   hwm_load;

    // Combinational view of the buffer: fill level, overflow and its rising edge
    always_comb begin
        next_rd    = last_rd_addr + L_ADR_ONE;
        wused_diff = wr_addr - next_rd;
        adr_match  = (wr_addr == last_rd_addr);
        ovf_n      = hdr_full | adr_match;
        wused_n    = wused_diff;
        if (ovf_n) begin
            wused_n = L_ADR_ONES;
        end
        af_n       = (wused_n >= af_thresh);
        rise       = ovf_n & ~overflow;
        hwm_load   = hwm_clr | (wused_n > wused_hwm);
    end

    // Read pointer follows the stop address of each fully read event; reset
    // to all-ones so the used count starts from address 0 after release
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_rd_addr <= L_ADR_ONES;
        end else if (rddone) begin
            last_rd_addr <= stop_addr;
        end
    end

    // Live status outputs, registered copies of this cycle's fill evaluation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow    <= 1'b0;
            almost_full <= 1'b0;
            wused       <= '0;
        end else begin
            overflow    <= ovf_n;
            almost_full <= af_n;
            wused       <= wused_n;
        end
    end

    // Sticky overflow flag; a new rise beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (rise) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

    // Saturating overflow event counter; a clear with a rise restarts at one
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (ovf_clr) begin
            ovf_cnt <= rise ? L_CNT_ONE : '0;
        end else if (rise && (ovf_cnt != L_CNT_MAX)) begin
            ovf_cnt <= ovf_cnt + L_CNT_ONE;
        end
    end

    // High-water mark of the used count; a clear reloads the present level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wused_hwm <= '0;
        end else if (hwm_load) begin
            wused_hwm <= wused_n;
        end
    end

endmodule : wvb_ovf_ctrl_chan

// File: rtl/wvb_ovf_ctrl_multi.sv
// Multi-channel waveform buffer overflow controller.
// Generates one independent channel tracker per waveform buffer and only
// slices the flattened per-channel buses; channel c uses slice [c*W +: W].
module wvb_ovf_ctrl_multi
    import wvb_ovf_ctrl_multi_pkg::*;
#(
    parameter int P_N_CHAN    = L_N_CHAN_DEF,
    parameter int P_ADR_WIDTH = L_ADR_WIDTH_DEF,
    parameter int P_CNT_WIDTH = L_CNT_WIDTH_DEF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [P_N_CHAN*P_ADR_WIDTH-1:0]   wvb_wr_addr,
    input  logic [P_N_CHAN*P_ADR_WIDTH-1:0]   stop_addr,
    input  logic [P_N_CHAN-1:0]               wvb_rddone,
    input  logic [P_N_CHAN-1:0]               hdr_full,
    input  logic [P_ADR_WIDTH-1:0]            af_thresh,
    input  logic [P_N_CHAN-1:0]               ovf_clr,
    input  logic [P_N_CHAN-1:0]               hwm_clr,
    output logic [P_N_CHAN-1:0]               overflow,
    output logic [P_N_CHAN-1:0]               almost_full,
    output logic [P_N_CHAN-1:0]               ovf_sticky,
    output logic [P_N_CHAN*P_ADR_WIDTH-1:0]   wvb_wused,
    output logic [P_N_CHAN*P_ADR_WIDTH-1:0]   wused_hwm,
    output logic [P_N_CHAN*P_CNT_WIDTH-1:0]   ovf_cnt
);

    // One tracker per channel; no shared state or arbitration between them
    for (genvar c = 0; c < P_N_CHAN; c++) begin : g_chan
        wvb_ovf_ctrl_chan #(
            .P_ADR_WIDTH (P_ADR_WIDTH),
            .P_CNT_WIDTH (P_CNT_WIDTH)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .wr_addr     (wvb_wr_addr[c*P_ADR_WIDTH +: P_ADR_WIDTH]),
            .stop_addr   (stop_addr[c*P_ADR_WIDTH +: P_ADR_WIDTH]),
            .rddone      (wvb_rddone[c]),
            .hdr_full    (hdr_full[c]),
            .af_thresh   (af_thresh),
            .ovf_clr     (ovf_clr[c]),
            .hwm_clr     (hwm_clr[c]),
            .overflow    (overflow[c]),
            .almost_full (almost_full[c]),
            .ovf_sticky  (ovf_sticky[c]),
            .wused       (wvb_wused[c*P_ADR_WIDTH +: P_ADR_WIDTH]),
            .wused_hwm   (wused_hwm[c*P_ADR_WIDTH +: P_ADR_WIDTH]),
            .ovf_cnt     (ovf_cnt[c*P_CNT_WIDTH +: P_CNT_WIDTH])
        );
    end

endmodule : wvb_ovf_ctrl_multi
